conv_mac_sequencer: RTL and testbench

- Control block that sequences the MAC array core through one convolution layer.
- For each output pixel it loops over the input-channel groups. Each group is one weight load followed by one data beat into the MAC array.
- It clears the accumulator on the first group and tags the last group so the output is marked valid after the MAC pipeline latency.
- It sits between the layer-level scheduler (start/done), the weight and feature buffers (req/valid), and the MAC core (load/valid/adder reset).

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_tag_pipe.sv | 35 +++
 rtl/conv_mac_sequencer.sv | 154 +++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer: state encoding and
// default widths/latency.
package conv_pkg;

    localparam int unsigned ACC_W_DEF    = 8;
    localparam int unsigned PIX_W_DEF    = 16;
    localparam int unsigned PIPE_LAT_DEF = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_FEED   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth 1-bit tag shift register that tracks pixel completions through
// the MAC pipeline; empty_o is high when no tag is in flight.
module conv_tag_pipe #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_i,
    output logic tag_o,
    output logic empty_o
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = tag_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o   = stage_q[DEPTH-1];
    assign empty_o = ~|stage_q;

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences the MAC array through one convolution layer (weight load + data
// beat per channel group). Optional perf counters: CONV_SEQ_PERF_CNT_EN.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] cfg_acc_num,
    input  logic [PIX_W-1:0] cfg_pix_num,
    output logic             busy,
    output logic             done,
    output logic             wgt_req,
    input  logic             wgt_valid,
    output logic             dat_req,
    input  logic             dat_valid,
    input  logic             out_stall,
    output logic             mac_wgt_load,
    output logic             mac_data_valid,
    output logic             adder_rst,
    output logic             mac_out_valid,
    output logic [ACC_W-1:0] grp_idx,
    output logic [PIX_W-1:0] pix_idx
`ifdef CONV_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
`endif
);

    logic [2:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_last_q, acc_last_d;
    logic [PIX_W-1:0] pix_last_q, pix_last_d;
    logic [ACC_W-1:0] grp_q, grp_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             tag_push;
    logic             tag_empty;

    assign wgt_req        = (state_q == ST_LOAD_W);
    assign dat_req        = (state_q == ST_FEED) & ~out_stall;
    assign mac_wgt_load   = wgt_req & wgt_valid;
    assign mac_data_valid = dat_req & dat_valid;
    assign adder_rst      = mac_data_valid & (grp_q == '0);
    assign busy           = (state_q == ST_LOAD_W) | (state_q == ST_FEED) | (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign grp_idx        = grp_q;
    assign pix_idx        = pix_q;

    always_comb begin
        state_d    = state_q;
        acc_last_d = acc_last_q;
        pix_last_d = pix_last_q;
        grp_d      = grp_q;
        pix_d      = pix_q;
        tag_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A group count of 0 behaves as a single group.
                    acc_last_d = (cfg_acc_num == '0) ? '0 : cfg_acc_num - ACC_W'(1);
                    pix_last_d = cfg_pix_num - PIX_W'(1);
                    grp_d      = '0;
                    pix_d      = '0;
                    state_d    = (cfg_pix_num == '0) ? ST_DRAIN : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (mac_wgt_load) begin
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (mac_data_valid) begin
                    if (grp_q != acc_last_q) begin
                        grp_d   = grp_q + ACC_W'(1);
                        state_d = ST_LOAD_W;
                    end else begin
                        grp_d    = '0;
                        pix_d    = pix_q + PIX_W'(1);
                        tag_push = 1'b1;
                        state_d  = (pix_q == pix_last_q) ? ST_DRAIN : ST_LOAD_W;
                    end
                end
            end
            ST_DRAIN: begin
                if (tag_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_last_q <= '0;
            pix_last_q <= '0;
            grp_q      <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_last_q <= acc_last_d;
            pix_last_q <= pix_last_d;
            grp_q      <= grp_d;
            pix_q      <= pix_d;
        end
    end

    conv_tag_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_i  (tag_push),
        .tag_o  (mac_out_valid),
        .empty_o(tag_empty)
    );

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;
    logic        stall_cyc;

    // Stall = waiting on weights, or a FEED cycle that issued no beat.
    assign stall_cyc = (wgt_req & ~wgt_valid) | ((state_q == ST_FEED) & ~mac_data_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (stall_cyc && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer: directed layer runs plus
// randomized handshakes against a transaction-level reference model.
module tb_conv_mac_sequencer;

    localparam int unsigned ACC_W    = 8;
    localparam int unsigned PIX_W    = 16;
    localparam int unsigned PIPE_LAT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ACC_W-1:0] cfg_acc_num = '0;
    logic [PIX_W-1:0] cfg_pix_num = '0;
    logic             busy, done, wgt_req, dat_req;
    logic             wgt_valid = 1'b0;
    logic             dat_valid = 1'b0;
    logic             out_stall = 1'b0;
    logic             mac_wgt_load, mac_data_valid, adder_rst, mac_out_valid;
    logic [ACC_W-1:0] grp_idx;
    logic [PIX_W-1:0] pix_idx;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0]      perf_cycles, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_mac_sequencer #(
        .ACC_W   (ACC_W),
        .PIX_W   (PIX_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_acc_num   (cfg_acc_num),
        .cfg_pix_num   (cfg_pix_num),
        .busy          (busy),
        .done          (done),
        .wgt_req       (wgt_req),
        .wgt_valid     (wgt_valid),
        .dat_req       (dat_req),
        .dat_valid     (dat_valid),
        .out_stall     (out_stall),
        .mac_wgt_load  (mac_wgt_load),
        .mac_data_valid(mac_data_valid),
        .adder_rst     (adder_rst),
        .mac_out_valid (mac_out_valid),
        .grp_idx       (grp_idx),
        .pix_idx       (pix_idx)
`ifdef CONV_SEQ_PERF_CNT_EN
        ,
        .perf_cycles   (perf_cycles),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wreq"}, 32'(wgt_req), 0);
        check({tag, "_dreq"}, 32'(dat_req), 0);
        check({tag, "_wload"}, 32'(mac_wgt_load), 0);
        check({tag, "_dvalid"}, 32'(mac_data_valid), 0);
        check({tag, "_arst"}, 32'(adder_rst), 0);
        check({tag, "_ovalid"}, 32'(mac_out_valid), 0);
        check({tag, "_grp"}, 32'(grp_idx), 0);
        check({tag, "_pix"}, 32'(pix_idx), 0);
    endtask

    // Runs one layer. Model: layer issues acc*pix (load, beat) pairs in order;
    // beat k belongs to group k%acc of pixel k/acc; a pixel's last beat at
    // cycle t yields mac_out_valid at t+PIPE_LAT and done at t+PIPE_LAT+2.
    task automatic run_layer(
        input  int acc, input int pix,
        input  int wpct, input int dpct, input int spct,
        input  int stall_from, input int stall_len,
        input  int wdelay, input bit rnd_start,
        output int done_at, output int loads, output int beats,
        output int movs, output int arsts, output int mov_gap);
        int eff, total, l, b, done_cyc, first_mov, last_mov, pc, ps;
        int comp[$];
        bit wv, dv, st, active, e_wreq, e_dreq, e_load, e_beat, e_arst, e_mov, e_busy, e_done;
        eff = (acc == 0) ? 1 : acc;
        total = eff * pix;
        l = 0; b = 0; movs = 0; arsts = 0; pc = 0; ps = 0;
        first_mov = -1; last_mov = -1;
        done_cyc = (pix == 0) ? 2 : -1;

        @(posedge clk); #1;
        start = 1'b1;
        cfg_acc_num = ACC_W'(acc);
        cfg_pix_num = PIX_W'(pix);
        wgt_valid = 1'b1; dat_valid = 1'b1; out_stall = 1'b0;
        @(negedge clk);
        check("pre_start_busy", 32'(busy), 0);
        check("pre_start_wreq", 32'(wgt_req), 0);
        @(posedge clk); #1;

        for (int c = 1; ; c++) begin
            if (c > 3000) begin
                checks++;
                failures++;
                $error("FAIL layer_timeout observed=%0d expected_done=%0d", c, done_cyc);
                break;
            end
            wv = ($urandom_range(99) < wpct) && (c > wdelay);
            dv = ($urandom_range(99) < dpct);
            st = ((c >= stall_from) && (c < stall_from + stall_len)) || ($urandom_range(99) < spct);
            wgt_valid = wv; dat_valid = dv; out_stall = st;
            start = rnd_start && ((done_cyc < 0) || (c <= done_cyc)) && ($urandom_range(3) == 0);
            cfg_acc_num = ACC_W'($urandom);
            cfg_pix_num = PIX_W'($urandom);
            @(negedge clk);

            active = (b < total);
            e_wreq = active && (l == b);
            e_dreq = active && (l > b) && !st;
            e_load = e_wreq && wv;
            e_beat = e_dreq && dv;
            e_arst = e_beat && ((b % eff) == 0);
            e_mov  = (comp.size() > 0) && (comp[0] == c);
            e_busy = (done_cyc < 0) || (c < done_cyc);
            e_done = (c == done_cyc);

            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("wgt_req", 32'(wgt_req), 32'(e_wreq));
            check("dat_req", 32'(dat_req), 32'(e_dreq));
            check("mac_wgt_load", 32'(mac_wgt_load), 32'(e_load));
            check("mac_data_valid", 32'(mac_data_valid), 32'(e_beat));
            check("adder_rst", 32'(adder_rst), 32'(e_arst));
            check("mac_out_valid", 32'(mac_out_valid), 32'(e_mov));
            check("grp_idx", 32'(grp_idx), 32'(b % eff));
            check("pix_idx", 32'(pix_idx), 32'(b / eff));

            if (e_busy) pc++;
            if ((e_wreq && !wv) || (active && (l > b) && !e_beat)) ps++;
            if (e_mov) begin
                void'(comp.pop_front());
                movs++;
                if (first_mov < 0) first_mov = c;
                last_mov = c;
            end
            if (e_arst) arsts++;
            if (e_load) l++;
            if (e_beat) begin
                if ((b % eff) == eff - 1) comp.push_back(c + int'(PIPE_LAT));
                b++;
                if (b == total) done_cyc = c + int'(PIPE_LAT) + 2;
            end
            if ((done_cyc >= 0) && (c == done_cyc + 1)) begin
`ifdef CONV_SEQ_PERF_CNT_EN
                check("perf_cycles", perf_cycles, 32'(pc));
                check("perf_stall", perf_stall, 32'(ps));
`endif
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        done_at = done_cyc;
        loads = l;
        beats = b;
        mov_gap = last_mov - first_mov;
    endtask

    initial begin
        int d, nl, nb, nm, na, gap;
        bit found;

        // Reset state
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single group, single pixel, valids held high
        run_layer(1, 1, 100, 100, 0, 0, 0, 0, 1'b0, d, nl, nb, nm, na, gap);
        check("s1_done_cycle", 32'(d), 8);
        check("s1_loads", 32'(nl), 1);
        check("s1_out_valids", 32'(nm), 1);

        // Three groups, two pixels
        run_layer(3, 2, 100, 100, 0, 0, 0, 0, 1'b0, d, nl, nb, nm, na, gap);
        check("s2_loads", 32'(nl), 6);
        check("s2_beats", 32'(nb), 6);
        check("s2_adder_rst", 32'(na), 2);
        check("s2_out_valids", 32'(nm), 2);
        check("s2_out_gap", 32'(gap), 6);
        check("s2_done_cycle", 32'(d), 18);

        // Same, with out_stall held for 5 cycles in the first FEED
        run_layer(3, 2, 100, 100, 0, 2, 5, 0, 1'b0, d, nl, nb, nm, na, gap);
        check("s3_beats", 32'(nb), 6);
        check("s3_out_gap", 32'(gap), 6);
        check("s3_done_cycle", 32'(d), 23);

        // Empty layer, with stray starts while busy
        run_layer(1, 0, 100, 100, 0, 0, 0, 0, 1'b1, d, nl, nb, nm, na, gap);
        check("s4_loads", 32'(nl), 0);
        check("s4_done_cycle", 32'(d), 2);

        // Reset while feeding pixel 1 of 2
        @(posedge clk); #1;
        start = 1'b1; cfg_acc_num = 8'd2; cfg_pix_num = 16'd2;
        wgt_valid = 1'b1; dat_valid = 1'b1; out_stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dat_req && (pix_idx == 16'd1)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $error("FAIL rst_mid_reach observed=0 expected=1");
        end
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        run_layer(1, 1, 100, 100, 0, 0, 0, 0, 1'b0, d, nl, nb, nm, na, gap);
        check("s5_done_cycle", 32'(d), 8);

        // Group count of 0 behaves as 1
        run_layer(0, 3, 70, 70, 20, 0, 0, 0, 1'b1, d, nl, nb, nm, na, gap);
        check("s6_beats", 32'(nb), 3);
        check("s6_out_valids", 32'(nm), 3);

        // Weights arrive 2 cycles late (perf stall = 2 when counters exist)
        run_layer(1, 1, 100, 100, 0, 0, 0, 2, 1'b0, d, nl, nb, nm, na, gap);
        check("s7_done_cycle", 32'(d), 10);

        // Randomized layers
        for (int r = 0; r < 6; r++) begin
            int ra, rp;
            ra = int'($urandom_range(4, 1));
            rp = int'($urandom_range(3, 1));
            run_layer(ra, rp, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(40, 0)), 0, 0, 0, 1'b1, d, nl, nb, nm, na, gap);
            check("rnd_loads", 32'(nl), 32'(ra * rp));
            check("rnd_out_valids", 32'(nm), 32'(rp));
            check("rnd_adder_rst", 32'(na), 32'(rp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
